// File: rtl/ddr_cmd_issuer_if.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_cmd_issuer_if
//  Brief    : Request handshake, stall and command-pulse bundle for the
//             DDR command issuer.
//  Revision : 1.0  initial release
// ============================================================================
interface ddr_cmd_issuer_if #(
    parameter int ROWW = 14
);
    logic            halt;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [ROWW-1:0] req_row;
    logic            ACT;
    logic            PR;
    logic            RD;
    logic            WR;
    logic            REF;
    logic [ROWW-1:0] row_out;
    logic            busy;

    // Requester / controller side
    modport master (
        output halt, req_valid, req_write, req_row,
        input  req_ready, ACT, PR, RD, WR, REF, row_out, busy
    );

    // Command issuer side
    modport slave (
        input  halt, req_valid, req_write, req_row,
        output req_ready, ACT, PR, RD, WR, REF, row_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/ddr_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_cmd_issuer
//  Brief    : Single-bank open-page DDR command sequencer. Turns read/write
//             requests into ACT/PR/RD/WR pulses honouring tRCD, tRP, tRAS,
//             and inserts periodic REF with tRFC recovery.
//  Revision : 1.0  initial release
// ============================================================================
module ddr_cmd_issuer #(
    parameter int TRCD  = 4,
    parameter int TRP   = 3,
    parameter int TRAS  = 8,
    parameter int TRFC  = 10,
    parameter int TREFI = 200,
    parameter int ROWW  = 14
) (
    input  logic             clk,
    input  logic             rst,
    ddr_cmd_issuer_if.slave  bus
);

    localparam int c_wait_max0 = (TRP > TRCD) ? TRP : TRCD;
    localparam int c_wait_max  = (c_wait_max0 > TRFC) ? c_wait_max0 : TRFC;
    localparam int c_wait_w    = $clog2(c_wait_max + 1);
    localparam int c_ras_w     = $clog2(TRAS + 1);
    localparam int c_refi_w    = $clog2(TREFI + 1);

    // Last count value of each wait state (state lasts PARAM-1 cycles)
    localparam logic [c_wait_w-1:0] c_trp_last  = c_wait_w'(TRP - 2);
    localparam logic [c_wait_w-1:0] c_trcd_last = c_wait_w'(TRCD - 2);
    localparam logic [c_wait_w-1:0] c_trfc_last = c_wait_w'(TRFC - 2);
    localparam logic [c_ras_w-1:0]  c_ras_max   = c_ras_w'(TRAS);
    localparam logic [c_refi_w-1:0] c_refi_last = c_refi_w'(TREFI - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE      = 3'd1,
        PRE_WAIT = 3'd2,
        ACTV     = 3'd3,
        ACT_WAIT = 3'd4,
        CMD      = 3'd5,
        REFR     = 3'd6,
        REF_WAIT = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic [c_ras_w-1:0]  r_ras_cnt;
    logic [c_refi_w-1:0] r_refi_cnt;
    logic                r_ref_pend;
    logic                r_ref_path;
    logic                r_row_open;
    logic [ROWW-1:0]     r_open_row;
    logic                r_lat_write;
    logic [ROWW-1:0]     r_lat_row;

    logic w_act, w_pr, w_rd, w_wr, w_ref;
    logic w_accept, w_ref_start, w_in_wait, w_gate;

    // State register; halt freezes the sequence in place
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else if (!bus.halt)
            r_state <= w_state_nxt;
    end

    // Next-state decode and raw command pulses for the current state
    always_comb begin
        w_state_nxt = r_state;
        w_act       = 1'b0;
        w_pr        = 1'b0;
        w_rd        = 1'b0;
        w_wr        = 1'b0;
        w_ref       = 1'b0;
        w_accept    = 1'b0;
        w_ref_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_ref_pend) begin
                    // Refresh wins over any request; close the page first
                    w_ref_start = 1'b1;
                    w_state_nxt = r_row_open ? PRE : REFR;
                end else if (bus.req_valid) begin
                    w_accept = 1'b1;
                    if (r_row_open && (bus.req_row == r_open_row))
                        w_state_nxt = CMD;
                    else if (r_row_open)
                        w_state_nxt = PRE;
                    else
                        w_state_nxt = ACTV;
                end
            end
            PRE: begin
                if (r_ras_cnt == c_ras_max) begin
                    w_pr = 1'b1;
                    if (TRP > 1)
                        w_state_nxt = PRE_WAIT;
                    else
                        w_state_nxt = r_ref_path ? REFR : ACTV;
                end
            end
            PRE_WAIT: begin
                if (r_wait_cnt == c_trp_last)
                    w_state_nxt = r_ref_path ? REFR : ACTV;
            end
            ACTV: begin
                w_act       = 1'b1;
                w_state_nxt = (TRCD > 1) ? ACT_WAIT : CMD;
            end
            ACT_WAIT: begin
                if (r_wait_cnt == c_trcd_last)
                    w_state_nxt = CMD;
            end
            CMD: begin
                w_rd        = !r_lat_write;
                w_wr        = r_lat_write;
                w_state_nxt = IDLE;
            end
            REFR: begin
                w_ref       = 1'b1;
                w_state_nxt = (TRFC > 1) ? REF_WAIT : IDLE;
            end
            REF_WAIT: begin
                if (r_wait_cnt == c_trfc_last)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_in_wait = (r_state == PRE_WAIT) || (r_state == ACT_WAIT) ||
                       (r_state == REF_WAIT);

    // Request latch, page tracking, timing counters and refresh scheduling
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat_write <= 1'b0;
            r_lat_row   <= '0;
            r_ref_path  <= 1'b0;
            r_row_open  <= 1'b0;
            r_open_row  <= '0;
            r_ras_cnt   <= '0;
            r_wait_cnt  <= '0;
            r_refi_cnt  <= '0;
            r_ref_pend  <= 1'b0;
        end else if (!bus.halt) begin
            if (w_accept) begin
                r_lat_write <= bus.req_write;
                r_lat_row   <= bus.req_row;
            end

            if (w_ref_start)
                r_ref_path <= r_row_open;
            else if (r_state == REFR)
                r_ref_path <= 1'b0;

            // The ACT cycle itself counts, so the counter equals cycles since ACT
            if (r_state == ACTV) begin
                r_row_open <= 1'b1;
                r_open_row <= r_lat_row;
                r_ras_cnt  <= c_ras_w'(1);
            end else begin
                if (w_pr)
                    r_row_open <= 1'b0;
                if (r_ras_cnt != c_ras_max)
                    r_ras_cnt <= r_ras_cnt + 1'b1;
            end

            r_wait_cnt <= (w_in_wait && (w_state_nxt == r_state)) ?
                          r_wait_cnt + 1'b1 : '0;

            if (r_refi_cnt == c_refi_last)
                r_refi_cnt <= '0;
            else
                r_refi_cnt <= r_refi_cnt + 1'b1;

            // Clearing wins, so an expiry while pending never queues a second REF
            if (r_state == REFR)
                r_ref_pend <= 1'b0;
            else if (r_refi_cnt == c_refi_last)
                r_ref_pend <= 1'b1;
        end
    end

    assign w_gate = !rst && !bus.halt;

    assign bus.ACT       = w_act && w_gate;
    assign bus.PR        = w_pr  && w_gate;
    assign bus.RD        = w_rd  && w_gate;
    assign bus.WR        = w_wr  && w_gate;
    assign bus.REF       = w_ref && w_gate;
    assign bus.req_ready = w_gate && (r_state == IDLE) && !r_ref_pend;
    assign bus.busy      = !rst && (r_state != IDLE);
    assign bus.row_out   = rst ? '0 : ((r_state == ACTV) ? r_lat_row : r_open_row);

endmodule
`default_nettype wire
